// File: rtl/i2c_fifo_master.sv
// Byte-level I2C master: START + address, then drains the TX FIFO (write) or fills the RX FIFO
// (read) with master clock stretching while the RX FIFO is full, and finishes with STOP.
module i2c_fifo_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CLK_DIV    = 250
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  start,
  input  logic [7:0]            adrr_r_w,
  input  logic                  empty_tx,
  input  logic [DATA_WIDTH-1:0] fifo_r_data_tx,
  output logic                  read_fifo_tx,
  input  logic                  full_rx,
  input  logic                  end_rx,
  output logic                  write_fifo_rx,
  output logic [DATA_WIDTH-1:0] fifo_w_data_rx,
  output logic                  transaction_ok,
  output logic                  nack,
  output logic                  busy,
  output logic                  scl_oe,
  output logic                  sda_oe,
  input  logic                  sda_i
);

  localparam int unsigned CntW = $clog2(CLK_DIV);

  typedef enum logic [3:0] {
    StIdle, StStart, StAddr, StAddrAck, StWrData, StWrAck, StRdData, StRdPush, StRdAck, StStop
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] qcnt_q;
  logic [1:0]      qtr_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            rw_q;
  logic            sda_smp_q;
  logic            rd_end_q;
  logic            load_q;

  logic q_end, bit_end, smp;
  assign q_end   = (qcnt_q == CntW'(CLK_DIV - 1));
  assign bit_end = q_end && (qtr_q == 2'd3);
  assign smp     = q_end && (qtr_q == 2'd1);

  logic unused_tx;
  assign unused_tx = ^fifo_r_data_tx[DATA_WIDTH-1:8];

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q        <= StIdle;
      qcnt_q         <= '0;
      qtr_q          <= '0;
      bit_q          <= '0;
      shift_q        <= '0;
      rw_q           <= 1'b0;
      sda_smp_q      <= 1'b0;
      rd_end_q       <= 1'b0;
      load_q         <= 1'b0;
      read_fifo_tx   <= 1'b0;
      write_fifo_rx  <= 1'b0;
      fifo_w_data_rx <= '0;
      transaction_ok <= 1'b0;
      nack           <= 1'b0;
      busy           <= 1'b0;
      scl_oe         <= 1'b0;
      sda_oe         <= 1'b0;
    end else begin
      read_fifo_tx  <= 1'b0;
      write_fifo_rx <= 1'b0;
      // Shared bit timing: SCL released for q1/q2, pulled low for q3/q0.
      // Later per-state assignments override these where a state needs different behaviour.
      if (state_q != StIdle) begin
        qcnt_q <= q_end ? '0 : qcnt_q + CntW'(1);
        if (q_end) qtr_q <= qtr_q + 2'd1;
        if (q_end && qtr_q == 2'd0) scl_oe <= 1'b0;
        if (q_end && qtr_q == 2'd2) scl_oe <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q        <= StStart;
            shift_q        <= adrr_r_w;
            rw_q           <= adrr_r_w[0];
            transaction_ok <= 1'b0;
            nack           <= 1'b0;
            busy           <= 1'b1;
            sda_oe         <= 1'b1;
            qcnt_q         <= '0;
            qtr_q          <= '0;
            bit_q          <= '0;
          end
        end
        StStart: begin
          if (q_end && qtr_q == 2'd1) begin
            scl_oe  <= 1'b1;
            qtr_q   <= '0;
            state_q <= StAddr;
          end
        end
        StAddr, StWrData: begin
          if (state_q == StWrData && load_q) begin
            // Byte boundary: one extra cycle with the counter held to fetch the next byte.
            qcnt_q <= '0;
            load_q <= 1'b0;
            if (empty_tx) begin
              state_q <= StStop;
            end else begin
              shift_q      <= fifo_r_data_tx[7:0];
              read_fifo_tx <= 1'b1;
            end
          end else begin
            if (qtr_q == 2'd0) sda_oe <= ~shift_q[7];
            if (bit_end) begin
              shift_q <= {shift_q[6:0], 1'b0};
              bit_q   <= bit_q + 3'd1;
              if (bit_q == 3'd7) state_q <= (state_q == StAddr) ? StAddrAck : StWrAck;
            end
          end
        end
        StAddrAck, StWrAck: begin
          if (qtr_q == 2'd0) sda_oe <= 1'b0;
          if (smp) sda_smp_q <= sda_i;
          if (bit_end) begin
            if (sda_smp_q) begin
              nack    <= 1'b1;
              state_q <= StStop;
            end else if (state_q == StWrAck || !rw_q) begin
              state_q <= StWrData;
              load_q  <= 1'b1;
            end else if (end_rx) begin
              state_q <= StStop;
            end else begin
              state_q <= StRdData;
            end
          end
        end
        StRdData: begin
          if (qtr_q == 2'd0) sda_oe <= 1'b0;
          if (smp) shift_q <= {shift_q[6:0], sda_i};
          if (bit_end) begin
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= StRdPush;
          end
        end
        StRdPush: begin
          // SCL stays low (from q3) while the RX FIFO is full.
          qcnt_q <= '0;
          if (!full_rx) begin
            write_fifo_rx  <= 1'b1;
            fifo_w_data_rx <= {{(DATA_WIDTH-8){1'b0}}, shift_q};
            state_q        <= StRdAck;
          end
        end
        StRdAck: begin
          if (q_end && qtr_q == 2'd0) begin
            sda_oe   <= ~end_rx;
            rd_end_q <= end_rx;
          end
          if (bit_end) state_q <= rd_end_q ? StStop : StRdData;
        end
        StStop: begin
          if (qtr_q == 2'd0) sda_oe <= 1'b1;
          if (q_end && qtr_q == 2'd1) sda_oe <= 1'b0;
          if (q_end && qtr_q == 2'd2) scl_oe <= 1'b0;
          if (bit_end) begin
            transaction_ok <= ~nack;
            busy           <= 1'b0;
            state_q        <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
